// File: rtl/pico_wb_master.sv
// pico_wb_master: bridge from the PicoRV32 native memory port to a pipelined
// Wishbone B4 master. One Wishbone cycle per CPU access, one access in flight.
// Slave errors (and, optionally, bus timeouts) complete the CPU access with
// ERR_RDATA and latch the failing address into sticky status registers.
// Optional feature macro: PICO_WB_TIMEOUT_EN enables the bus-timeout counter.
module pico_wb_master #(
  parameter logic [31:0] WIN_BASE  = 32'h8000_0000,
  parameter logic [31:0] WIN_MASK  = 32'hFFFF_FF00,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF,
  parameter int          TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        i_resetn,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [3:0]  i_mem_wstrb,
  output logic        o_hit,
  output logic        o_mem_ready,
  output logic [31:0] o_mem_rdata,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  output logic        o_err,
  output logic        o_err_tmo,
  output logic [31:0] o_err_addr,
  input  logic        i_err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  sel_q, sel_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  // Completion causes for the current Wishbone cycle
  logic fin_ack, fin_err, fin_tmo;
  logic tmo_hit;

`ifdef PICO_WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_tmo_q, err_tmo_d;
  // Counter holds k-1 on the k-th edge after cyc rises; abort on edge TIMEOUT
  assign tmo_hit   = (tmo_cnt_q == CW'(TIMEOUT - 1));
  assign o_err_tmo = err_tmo_q;
`else
  // No counter: a silent slave stalls the CPU forever
  assign tmo_hit   = 1'b0;
  assign o_err_tmo = 1'b0;
`endif

  assign o_hit       = i_mem_valid && ((i_mem_addr & WIN_MASK) == WIN_BASE);
  assign o_mem_ready = ready_q;
  assign o_mem_rdata = rdata_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = data_q;
  assign o_wb_sel    = sel_q;
  assign o_err       = err_q;
  assign o_err_addr  = err_addr_q;

  // Next-state, bus outputs, completion data and sticky error flags
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sel_d      = sel_q;
    ready_d    = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    fin_ack    = 1'b0;
    fin_err    = 1'b0;
    fin_tmo    = 1'b0;
`ifdef PICO_WB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    err_tmo_d  = err_tmo_q;
`endif

    // Clear first so that an error in the same cycle overrides it below
    if (i_err_clr) begin
      err_d = 1'b0;
`ifdef PICO_WB_TIMEOUT_EN
      err_tmo_d = 1'b0;
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (o_hit) begin
          addr_d  = i_mem_addr;
          data_d  = i_mem_wdata;
          we_d    = |i_mem_wstrb;
          sel_d   = (|i_mem_wstrb) ? i_mem_wstrb : 4'hF;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = ST_REQ;
`ifdef PICO_WB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      ST_REQ: begin
`ifdef PICO_WB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        if (i_wb_err) begin
          fin_err = 1'b1;
        end else if (!i_wb_stall && i_wb_ack) begin
          fin_ack = 1'b1;
        end else if (tmo_hit) begin
          fin_tmo = 1'b1;
        end else if (!i_wb_stall) begin
          // Request accepted; keep cyc open for the response
          stb_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
`ifdef PICO_WB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        if (i_wb_err) begin
          fin_err = 1'b1;
        end else if (i_wb_ack) begin
          fin_ack = 1'b1;
        end else if (tmo_hit) begin
          fin_tmo = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any completion closes the bus cycle and pulses ready for one cycle
    if (fin_ack || fin_err || fin_tmo) begin
      state_d = ST_DONE;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      ready_d = 1'b1;
      if (fin_ack) begin
        rdata_d = we_q ? data_q : i_wb_data;
      end else begin
        rdata_d = ERR_RDATA;
      end
    end

    if (fin_err || fin_tmo) begin
      err_d      = 1'b1;
      err_addr_d = addr_q;
`ifdef PICO_WB_TIMEOUT_EN
      err_tmo_d  = fin_tmo;
`endif
    end
  end

  // State and output registers, asynchronously reset
  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= ST_IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

`ifdef PICO_WB_TIMEOUT_EN
  // Timeout counter and timeout-cause flag
  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      tmo_cnt_q <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_tmo_q <= err_tmo_d;
    end
  end
`endif

endmodule

// File: doc/pico_wb_master.md
# pico_wb_master

Parametrised bridge from the PicoRV32 native memory port to a pipelined Wishbone B4 master. It claims one address window (base/mask), runs one Wishbone cycle per CPU access, and returns `mem_ready`/`mem_rdata` to the core. It also handles slave error and optional bus timeout: it completes the CPU access with a fixed error word and records the failing address in sticky status registers. It sits beside the SRAM/UART/timer slaves in the top-level address decoder.

## Interface
- `WIN_BASE`, 32'h8000_0000: window base address.
- `WIN_MASK`, 32'hFFFF_FF00: the window is hit when `(i_mem_addr & WIN_MASK) == WIN_BASE`.
- `ERR_RDATA`, 32'hDEAD_BEEF: read data returned to the CPU on error or timeout.
- `TIMEOUT`, 64: cycles from `o_wb_cyc` rise to abort. Must be ≥2. Used only with `PICO_WB_TIMEOUT_EN`.

- `clk`  in  1  system clock
- `i_resetn`  in  1  reset, asynchronous, active-low
- `i_mem_valid`  in  1  CPU request valid
- `i_mem_addr`  in  32  CPU byte address
- `i_mem_wdata`  in  32  CPU write data
- `i_mem_wstrb`  in  4  CPU byte strobes; 0 means read
- `o_hit`  out  1  combinational: `i_mem_valid` && window match (feeds top-level ready/rdata mux)
- `o_mem_ready`  out  1  registered one-cycle completion pulse
- `o_mem_rdata`  out  32  registered read data, valid while `o_mem_ready`
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each  Wishbone master controls
- `o_wb_addr`  out  32  Wishbone address (full byte address)
- `o_wb_data`  out  32  write data
- `o_wb_sel`  out  4  byte selects
- `i_wb_data`  in  32  read data
- `i_wb_ack`, `i_wb_stall`, `i_wb_err`  in  1 each  slave responses
- `o_err`  out  1  sticky error flag
- `o_err_tmo`  out  1  sticky flag: the last recorded error was a timeout
- `o_err_addr`  out  32  address of the last failed access
- `i_err_clr`  in  1  synchronous clear of `o_err` and `o_err_tmo`

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - On `o_hit`, latch address, data and strobes into the Wishbone outputs.
  - `o_wb_we = |i_mem_wstrb`.
  - `o_wb_sel = i_mem_wstrb` for writes, 4'hF for reads.
  - Assert `o_wb_cyc` and `o_wb_stb`, then go to REQ.
- **REQ**
  - When `!i_wb_stall`, drop `o_wb_stb`.
  - If `i_wb_ack` is seen in the same cycle, go to DONE. Otherwise go to WAIT.
  - While stalled, hold all request outputs stable.
- **WAIT**
  - `o_wb_cyc` stays high and `o_wb_stb` stays low.
  - On `i_wb_ack`, go to DONE.
- **Error**
  - `i_wb_err` while `o_wb_cyc` is high, in REQ or WAIT, takes priority over ack.
  - Drop cyc/stb, set `o_err`, clear `o_err_tmo`, load `o_err_addr = o_wb_addr`, go to DONE.
- **DONE**
  - `o_mem_ready` = 1 for exactly one cycle, with cyc/stb low.
  - `o_mem_rdata`:
    - read ack: `i_wb_data` captured on the ack cycle;
    - write ack: `o_wb_data`;
    - error: `ERR_RDATA`.
  - Return to IDLE. The next request is not accepted in the DONE cycle.
- **Error flags**
  - `i_err_clr` and a new error in the same cycle: the error wins.
  - `o_err_addr` is not cleared by `i_err_clr`.
- **Reset**
  - Applies asynchronously in any state, including mid-cycle.
  - Outputs go to: cyc/stb/we 0, addr/data 0, sel 0, `o_mem_ready` 0, `o_mem_rdata` 0, `o_err` 0, `o_err_tmo` 0, `o_err_addr` 0.
  - FSM goes to IDLE.
- Only one access is outstanding at a time; no pipelining across CPU requests.

## Timing
- Zero-wait slave (no stall, ack the cycle after stb): `i_mem_valid` sampled at edge 0, cyc/stb high after edge 0, ack at edge 1, `o_mem_ready` high after edge 2.
- That is 3 cycles from valid to ready. Each stall or ack-wait cycle adds 1.
- `o_hit` is combinational from `i_mem_valid`/`i_mem_addr`. Every other output is registered.
- PicoRV32 holds `i_mem_valid` until `o_mem_ready`. The bridge ignores `i_mem_valid` outside IDLE.

## Configuration
- `PICO_WB_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT+1)` resets on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches `TIMEOUT` with no ack/err: drop cyc/stb, set `o_err` and `o_err_tmo`, load `o_err_addr`, go to DONE with `ERR_RDATA`.
  - Ack or err on the same cycle the count is reached takes priority over timeout.
- Not defined:
  - No counter. A silent slave hangs the CPU.
  - `o_err_tmo` is tied to 0.

## Test plan
- Read 0x8000_0004, slave acks next cycle with 0x1234_5678 → `o_wb_sel`=F, `o_wb_we`=0, `o_mem_rdata`=0x1234_5678, ready 3 cycles after valid.
- Write 0x8000_0000, wstrb=4'b0011, data 0x0000_00AA, slave stalls 2 cycles then acks → stb held for 3 cycles, sel=4'b0011, ready 5 cycles after valid, `o_mem_rdata`=0xAA.
- Read 0x8000_0010, slave asserts `i_wb_err` → `o_mem_rdata`=0xDEAD_BEEF, `o_err`=1, `o_err_addr`=0x8000_0010; then pulse `i_err_clr` → `o_err`=0 and `o_err_addr` unchanged.
- With `PICO_WB_TIMEOUT_EN` and TIMEOUT=8, slave never responds → cyc drops 8 cycles after rising, `o_err_tmo`=1, ready carries 0xDEAD_BEEF.
- Drive `i_resetn` low in WAIT → cyc/stb drop 0 immediately; after release a read to 0x0000_1000 gives `o_hit`=0 and no Wishbone cycle.
- Back-to-back reads: second valid presented the cycle after ready → the second cycle starts only after DONE→IDLE with no overlap of cyc.
